decode_stage_hs: RTL and testbench

//  RV32 decode stage: register file, immediate generation, load-use hazard detection, ID/EX pipeline register.

---
 rtl/decode_stage_hs.sv | 225 ++++++++++++++++++++++
 tb/tb_decode_stage_hs.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_hs
// Description : RV32 decode stage. Register file, immediate generation,
//               load-use hazard detection and an ID/EX pipeline register,
//               with valid/ready handshakes toward fetch and execute.
//               Optional macro DECODE_WB_BYPASS_EN: a write-back to the
//               register being read returns wb_data in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_hs #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int CW_IN_W  = 15,
    parameter int CW_EX_W  = 13,
    parameter int ALUOP_W  = 4,
    parameter int LOAD_BIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        ir_in,
    input  logic [XLEN-1:0]    pc_in,
    input  logic [XLEN-1:0]    npc_in,
    input  logic [CW_IN_W-1:0] cw_in,
    input  logic [ALUOP_W-1:0] aluop_in,
    input  logic               wb_en,
    input  logic [4:0]         wb_addr,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               flush,
    input  logic               ex_ready,
    output logic               ex_valid,
    output logic [XLEN-1:0]    r1,
    output logic [XLEN-1:0]    r2,
    output logic [XLEN-1:0]    imm_out,
    output logic [XLEN-1:0]    pc_out,
    output logic [XLEN-1:0]    npc_out,
    output logic [CW_EX_W-1:0] cw_exe,
    output logic [ALUOP_W-1:0] aluop_exe,
    output logic [4:0]         rd_out,
    output logic [4:0]         rs1_out,
    output logic [4:0]         rs2_out,
    output logic               hazard
);

    localparam int         c_AW   = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [5:0] c_NREG = 6'(NREG);

    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    // Register file; entry 0 is never written so it reads back as zero
    logic [XLEN-1:0] r_rf [NREG];

    // ID/EX pipeline register
    logic               r_ex_valid;
    logic [XLEN-1:0]    r_r1;
    logic [XLEN-1:0]    r_r2;
    logic [XLEN-1:0]    r_imm;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_npc;
    logic [CW_EX_W-1:0] r_cw;
    logic [ALUOP_W-1:0] r_aluop;
    logic [4:0]         r_rd;
    logic [4:0]         r_rs1;
    logic [4:0]         r_rs2;

    // Decoded instruction fields
    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic            w_rd1_en;
    logic            w_rd2_en;
    logic            w_wb_we;
    logic [XLEN-1:0] w_r1;
    logic [XLEN-1:0] w_r2;
    logic [XLEN-1:0] w_imm;
    logic            w_hazard;
    logic            w_stall;

    assign w_opcode = ir_in[6:0];
    assign w_rs1    = ir_in[19:15];
    assign w_rs2    = ir_in[24:20];
    assign w_rd     = ir_in[11:7];
    assign w_rd1_en = cw_in[CW_IN_W-1];
    assign w_rd2_en = cw_in[CW_IN_W-2];

    // Out-of-range indices (RV32E) and x0 are silently ignored
    assign w_wb_we = wb_en && (wb_addr != 5'd0) && ({1'b0, wb_addr} < c_NREG);

    // Register file write port, independent of stall and flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wb_we) begin
            r_rf[wb_addr[c_AW-1:0]] <= wb_data;
        end
    end

    // rs1 read port: zero when disabled, x0 or out of range
    always_comb begin
        w_r1 = '0;
        if (w_rd1_en && (w_rs1 != 5'd0) && ({1'b0, w_rs1} < c_NREG)) begin
            w_r1 = r_rf[w_rs1[c_AW-1:0]];
`ifdef DECODE_WB_BYPASS_EN
            if (wb_en && (wb_addr == w_rs1)) begin
                w_r1 = wb_data;
            end
`endif
        end
    end

    // rs2 read port: zero when disabled, x0 or out of range
    always_comb begin
        w_r2 = '0;
        if (w_rd2_en && (w_rs2 != 5'd0) && ({1'b0, w_rs2} < c_NREG)) begin
            w_r2 = r_rf[w_rs2[c_AW-1:0]];
`ifdef DECODE_WB_BYPASS_EN
            if (wb_en && (wb_addr == w_rs2)) begin
                w_r2 = wb_data;
            end
`endif
        end
    end

    // Sign-extended immediate selected by opcode format
    always_comb begin
        w_imm = '0;
        case (w_opcode)
            c_OP_IMM, c_OP_LOAD, c_OP_JALR:
                w_imm = {{(XLEN-12){ir_in[31]}}, ir_in[31:20]};
            c_OP_STORE:
                w_imm = {{(XLEN-12){ir_in[31]}}, ir_in[31:25], ir_in[11:7]};
            c_OP_BRANCH:
                w_imm = {{(XLEN-12){ir_in[31]}}, ir_in[7], ir_in[30:25], ir_in[11:8], 1'b0};
            c_OP_LUI, c_OP_AUIPC:
                w_imm = {{(XLEN-31){ir_in[31]}}, ir_in[30:12], 12'b0};
            c_OP_JAL:
                w_imm = {{(XLEN-20){ir_in[31]}}, ir_in[19:12], ir_in[20], ir_in[30:21], 1'b0};
            default:
                w_imm = '0;
        endcase
    end

    // Load in EX whose destination feeds a source read by this instruction
    assign w_hazard = in_valid && r_ex_valid && r_cw[LOAD_BIT] && (r_rd != 5'd0) &&
                      ((w_rd1_en && (r_rd == w_rs1)) || (w_rd2_en && (r_rd == w_rs2)));

    assign w_stall  = r_ex_valid && !ex_ready;
    assign in_ready = flush || (!w_hazard && !w_stall);
    assign hazard   = w_hazard;

    // ID/EX update: flush > backpressure hold > bubble > load > idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_valid <= 1'b0;
            r_r1       <= '0;
            r_r2       <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_npc      <= '0;
            r_cw       <= '0;
            r_aluop    <= '0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
            r_r1       <= '0;
            r_r2       <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_npc      <= '0;
            r_cw       <= '0;
            r_aluop    <= '0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
        end else if (w_stall) begin
            r_ex_valid <= r_ex_valid;
        end else if (w_hazard) begin
            r_ex_valid <= 1'b0;
            r_cw       <= '0;
            r_aluop    <= '0;
        end else if (in_valid) begin
            r_ex_valid <= 1'b1;
            r_r1       <= w_r1;
            r_r2       <= w_r2;
            r_imm      <= w_imm;
            r_pc       <= pc_in;
            r_npc      <= npc_in;
            r_cw       <= cw_in[CW_EX_W-1:0];
            r_aluop    <= aluop_in;
            r_rd       <= w_rd;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
        end else begin
            r_ex_valid <= 1'b0;
        end
    end

    assign ex_valid  = r_ex_valid;
    assign r1        = r_r1;
    assign r2        = r_r2;
    assign imm_out   = r_imm;
    assign pc_out    = r_pc;
    assign npc_out   = r_npc;
    assign cw_exe    = r_cw;
    assign aluop_exe = r_aluop;
    assign rd_out    = r_rd;
    assign rs1_out   = r_rs1;
    assign rs2_out   = r_rs2;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage_hs
// Description : Scoreboard bench for decode_stage_hs. Directed instructions
//               push their hand-computed ID/EX image into a queue; a monitor
//               pops and compares on every EX handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ir_in;
    logic [31:0] pc_in;
    logic [31:0] npc_in;
    logic [14:0] cw_in;
    logic [3:0]  aluop_in;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm_out;
    logic [31:0] pc_out;
    logic [31:0] npc_out;
    logic [12:0] cw_exe;
    logic [3:0]  aluop_exe;
    logic [4:0]  rd_out;
    logic [4:0]  rs1_out;
    logic [4:0]  rs2_out;
    logic        hazard;

    always #5 clk = ~clk;

    decode_stage_hs #(
        .XLEN(32), .NREG(32), .CW_IN_W(15), .CW_EX_W(13), .ALUOP_W(4), .LOAD_BIT(0)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ir_in(ir_in), .pc_in(pc_in), .npc_in(npc_in),
        .cw_in(cw_in), .aluop_in(aluop_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .r1(r1), .r2(r2), .imm_out(imm_out), .pc_out(pc_out), .npc_out(npc_out),
        .cw_exe(cw_exe), .aluop_exe(aluop_exe),
        .rd_out(rd_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
        .hazard(hazard)
    );

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [12:0] cw;
        logic [3:0]  aluop;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] pc      = 32'h0000_1000;
    int          t_waits;
    bit          t_haz;
    logic        t_acc_ev;
    logic [12:0] t_acc_cw;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per EX handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && ex_valid === 1'b1 && ex_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: output rd_out=%0d, expected no output", rd_out);
            end else begin
                e = sb.pop_front();
                chk("out_r1",    64'(r1),        64'(e.r1));
                chk("out_r2",    64'(r2),        64'(e.r2));
                chk("out_imm",   64'(imm_out),   64'(e.imm));
                chk("out_pc",    64'(pc_out),    64'(e.pc));
                chk("out_npc",   64'(npc_out),   64'(e.npc));
                chk("out_cw",    64'(cw_exe),    64'(e.cw));
                chk("out_aluop", 64'(aluop_exe), 64'(e.aluop));
                chk("out_rd",    64'(rd_out),    64'(e.rd));
                chk("out_rs1",   64'(rs1_out),   64'(e.rs1));
                chk("out_rs2",   64'(rs2_out),   64'(e.rs2));
            end
        end
    end

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    task automatic send(input logic [31:0] ir, input logic [14:0] cw, input logic [3:0] aop,
                        input logic [31:0] e_r1, input logic [31:0] e_r2,
                        input logic [31:0] e_imm, input logic [4:0] e_rd, input bit drop);
        exp_t e;
        bit   done;
        in_valid = 1'b1; ir_in = ir; cw_in = cw; aluop_in = aop;
        pc_in = pc; npc_in = pc + 32'd4;
        t_waits = 0; t_haz = 1'b0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (hazard) t_haz = 1'b1;
            if (in_ready) begin
                done = 1'b1;
            end else begin
                t_waits++;
                if (t_waits > 20) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL send_timeout: in_ready 0 for %0d cycles, expected 1", t_waits);
                    done = 1'b1;
                end
            end
        end
        t_acc_ev = ex_valid;
        t_acc_cw = cw_exe;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!drop) begin
            e.r1 = e_r1; e.r2 = e_r2; e.imm = e_imm;
            e.pc = pc; e.npc = pc + 32'd4;
            e.cw = cw[12:0]; e.aluop = aop; e.rd = e_rd;
            e.rs1 = ir[19:15]; e.rs2 = ir[24:20];
            sb.push_back(e);
        end
        pc = pc + 32'd4;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; ir_in = '0; pc_in = '0; npc_in = '0;
        cw_in = '0; aluop_in = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0; ex_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_valid", 64'(ex_valid), 64'd0);
        chk("rst_r1",       64'(r1),       64'd0);
        chk("rst_cw",       64'(cw_exe),   64'd0);
        chk("rst_pc",       64'(pc_out),   64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Register preload; the write to x0 must be ignored
        wb(5'd5, 32'hDEAD_BEEF);
        wb(5'd1, 32'h0000_0100);
        wb(5'd2, 32'h0000_0022);
        wb(5'd7, 32'h0000_0077);
        wb(5'd9, 32'h0000_0055);
        wb(5'd0, 32'h0000_FFFF);

        // add x6,x5,x5
        send(32'h0052_8333, 15'h60AA, 4'h1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 5'd6, 1'b0);
        chk("add_no_wait",   64'(t_waits),  64'd0);
        chk("add_latency",   64'(ex_valid), 64'd1);

        // lw x7,8(x1) then dependent add x8,x7,x2
        send(32'h0080_A383, 15'h4041, 4'h0, 32'h0000_0100, 32'h0, 32'h8, 5'd7, 1'b0);
        send(32'h0023_8433, 15'h60AA, 4'h1, 32'h0000_0077, 32'h0000_0022, 32'h0, 5'd8, 1'b0);
        chk("lu_stall_cycles", 64'(t_waits),  64'd1);
        chk("lu_hazard_seen",  64'(t_haz),    64'd1);
        chk("lu_bubble_valid", 64'(t_acc_ev), 64'd0);
        chk("lu_bubble_cw",    64'(t_acc_cw), 64'd0);
        repeat (2) @(posedge clk); #1;

        // Backpressure: addi x11,x2,5 held while sw x5,-4(x2) waits
        ex_ready = 1'b0;
        send(32'h0051_0593, 15'h4012, 4'h2, 32'h0000_0022, 32'h0, 32'h5, 5'd11, 1'b0);
        in_valid = 1'b1; ir_in = 32'hFE51_2E23; cw_in = 15'h6100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_ex_valid", 64'(ex_valid), 64'd1);
            chk("bp_r1_hold",  64'(r1),       64'h22);
            chk("bp_imm_hold", 64'(imm_out),  64'h5);
            chk("bp_rd_hold",  64'(rd_out),   64'd11);
            @(posedge clk); #1;
        end
        ex_ready = 1'b1;
        send(32'hFE51_2E23, 15'h6100, 4'h3, 32'h0000_0022, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 5'd28, 1'b0);
        chk("bp_release_wait", 64'(t_waits), 64'd0);

        // Flush squashes lui x12 entering ID/EX
        flush = 1'b1;
        send(32'hABCD_E637, 15'h0200, 4'h4, 32'h0, 32'h0, 32'hABCD_E000, 5'd12, 1'b1);
        flush = 1'b0;
        chk("fl_in_ready", 64'(t_waits),  64'd0);
        chk("fl_ex_valid", 64'(ex_valid), 64'd0);
        chk("fl_cw",       64'(cw_exe),   64'd0);
        chk("fl_r1",       64'(r1),       64'd0);
        chk("fl_rd",       64'(rd_out),   64'd0);

        // Immediate formats and x0 reads
        send(32'hABCD_E637, 15'h0200, 4'h4, 32'h0, 32'h0, 32'hABCD_E000, 5'd12, 1'b0);
        send(32'hFF9F_F06F, 15'h0400, 4'h5, 32'h0, 32'h0, 32'hFFFF_FFF8, 5'd0, 1'b0);
        send(32'h0020_8863, 15'h6800, 4'h6, 32'h0000_0100, 32'h0000_0022, 32'h10, 5'd16, 1'b0);
        send(32'h0000_06B3, 15'h60AA, 4'h1, 32'h0, 32'h0, 32'h0, 5'd13, 1'b0);

        // Write-back to x9 in the same cycle addi x10,x9,-1 is decoded
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_1234;
`ifdef DECODE_WB_BYPASS_EN
        send(32'hFFF4_8513, 15'h4012, 4'h2, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 5'd10, 1'b0);
`else
        send(32'hFFF4_8513, 15'h4012, 4'h2, 32'h0000_0055, 32'h0, 32'hFFFF_FFFF, 5'd10, 1'b0);
`endif
        wb_en = 1'b0;
        chk("byp_no_wait", 64'(t_waits), 64'd0);
        send(32'h0004_8733, 15'h60AA, 4'h1, 32'h0000_1234, 32'h0, 32'h0, 5'd14, 1'b0);
        repeat (2) @(posedge clk); #1;

        // Reset while ID/EX is stalled
        ex_ready = 1'b0;
        send(32'h0052_8333, 15'h60AA, 4'h1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 5'd6, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_ex_valid", 64'(ex_valid), 64'd0);
        chk("mr_r1",       64'(r1),       64'd0);
        chk("mr_cw",       64'(cw_exe),   64'd0);
        chk("mr_rd",       64'(rd_out),   64'd0);
        chk("mr_pc",       64'(pc_out),   64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        ex_ready = 1'b1;
        @(negedge clk);
        chk("mr_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        // Register file was cleared by reset
        send(32'h0052_8333, 15'h60AA, 4'h1, 32'h0, 32'h0, 32'h0, 5'd6, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
